// File: rtl/projection_receiver.sv
// Tracklet projection receiver: ping-pong local buffer with decoded
// read port, plus/minus neighbour FIFOs with valid/ready handshake.

module projection_fifo #(
  parameter int W    = 54,
  parameter int BITS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         drop
);
  localparam int DEPTH = 2**BITS;

  logic [W-1:0]  mem_q [DEPTH];
  logic [BITS:0] wr_ptr_q, wr_ptr_d;
  logic [BITS:0] rd_ptr_q, rd_ptr_d;
  logic          empty, full, pop, acc;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[BITS] != rd_ptr_q[BITS]) &&
            (wr_ptr_q[BITS-1:0] == rd_ptr_q[BITS-1:0]);
    pop   = ~empty & ready;
    // a full FIFO still takes a word when its head leaves this cycle
    acc   = push & (~full | pop);
    drop  = push & full & ~pop;
    wr_ptr_d = wr_ptr_q + {{BITS{1'b0}}, acc};
    rd_ptr_d = rd_ptr_q + {{BITS{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (acc) mem_q[wr_ptr_q[BITS-1:0]] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q[BITS-1:0]];
  assign valid = ~empty;
endmodule

module projection_receiver #(
  parameter int ADDR_BITS = 6,
  parameter int FIFO_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_proc,
  input  logic                 start,
  input  logic [53:0]          projection,
  input  logic                 valid_proj,
  input  logic                 valid_projPlus,
  input  logic                 valid_projMinus,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_valid,
  output logic [3:0]           rd_tc_index,
  output logic [5:0]           rd_index,
  output logic [13:0]          rd_phi,
  output logic [11:0]          rd_z,
  output logic [6:0]           rd_phider,
  output logic [7:0]           rd_zder,
  output logic [ADDR_BITS:0]   nproj,
  output logic [53:0]          plus_data,
  output logic                 plus_valid,
  input  logic                 plus_ready,
  output logic [53:0]          minus_data,
  output logic                 minus_valid,
  input  logic                 minus_ready,
  output logic                 err_overflow,
  output logic                 err_multi
);
  localparam int DEPTH = 2**ADDR_BITS;
  localparam int CW    = ADDR_BITS + 1;

  // bits [10:8] are never decoded, so they are not stored locally
  logic [50:0]   mem_q [2][DEPTH];
  logic          wr_bank_q, wr_bank_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d, cnt_nx;
  logic [CW-1:0] nproj_q, nproj_d;
  logic          rd_valid_q, rd_valid_d;
  logic [50:0]   rd_word_q, rd_word_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_multi_q, err_multi_d;
  logic          loc, mns, pls, multi, wr_ok;
  logic          plus_drop, minus_drop;

  always_comb begin
    loc   = en_proc & valid_proj;
    mns   = en_proc & valid_projMinus & ~valid_proj;
    pls   = en_proc & valid_projPlus & ~valid_proj & ~valid_projMinus;
    multi = en_proc & ((valid_proj & valid_projMinus) |
                       (valid_proj & valid_projPlus) |
                       (valid_projMinus & valid_projPlus));
    wr_ok  = loc & ~wr_cnt_q[ADDR_BITS];
    cnt_nx = wr_cnt_q + {{ADDR_BITS{1'b0}}, wr_ok};

    wr_bank_d = wr_bank_q;
    wr_cnt_d  = cnt_nx;
    nproj_d   = nproj_q;
    if (start) begin
      nproj_d   = cnt_nx;
      wr_bank_d = ~wr_bank_q;
      wr_cnt_d  = '0;
    end

    rd_valid_d = rd_en;
    rd_word_d  = rd_word_q;
    if (rd_en) rd_word_d = mem_q[~wr_bank_q][rd_addr];

    err_ovf_d = err_ovf_q | (loc & wr_cnt_q[ADDR_BITS]) |
                plus_drop | minus_drop;
    err_multi_d = err_multi_q | multi;
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem_q[wr_bank_q][wr_cnt_q[ADDR_BITS-1:0]] <=
        {projection[53:11], projection[7:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      nproj_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_word_q   <= '0;
      err_ovf_q   <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      nproj_q     <= nproj_d;
      rd_valid_q  <= rd_valid_d;
      rd_word_q   <= rd_word_d;
      err_ovf_q   <= err_ovf_d;
      err_multi_q <= err_multi_d;
    end
  end

  projection_fifo #(.W(54), .BITS(FIFO_BITS)) u_plus (
    .clk(clk), .rst_n(reset), .push(pls), .din(projection),
    .ready(plus_ready), .dout(plus_data), .valid(plus_valid),
    .drop(plus_drop)
  );

  projection_fifo #(.W(54), .BITS(FIFO_BITS)) u_minus (
    .clk(clk), .rst_n(reset), .push(mns), .din(projection),
    .ready(minus_ready), .dout(minus_data), .valid(minus_valid),
    .drop(minus_drop)
  );

  assign rd_valid     = rd_valid_q;
  assign rd_tc_index  = rd_word_q[50:47];
  assign rd_index     = rd_word_q[46:41];
  assign rd_phi       = rd_word_q[40:27];
  assign rd_z         = rd_word_q[26:15];
  assign rd_phider    = rd_word_q[14:8];
  assign rd_zder      = rd_word_q[7:0];
  assign nproj        = nproj_q;
  assign err_overflow = err_ovf_q;
  assign err_multi    = err_multi_q;
endmodule

// File: tb/tb_projection_receiver.sv
// Directed bench for projection_receiver with queue scoreboards
// for the local buffer and the plus/minus FIFOs.

module tb_projection_receiver;
  localparam int AB = 6;

  logic          clk = 0, reset = 1, en_proc = 0, start = 0;
  logic [53:0]   projection = '0;
  logic          valid_proj = 0, valid_projPlus = 0, valid_projMinus = 0;
  logic          rd_en = 0;
  logic [AB-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [3:0]    rd_tc_index;
  logic [5:0]    rd_index;
  logic [13:0]   rd_phi;
  logic [11:0]   rd_z;
  logic [6:0]    rd_phider;
  logic [7:0]    rd_zder;
  logic [AB:0]   nproj;
  logic [53:0]   plus_data, minus_data;
  logic          plus_valid, minus_valid;
  logic          plus_ready = 0, minus_ready = 0;
  logic          err_overflow, err_multi;

  logic [53:0] loc_q[$], pls_q[$], mns_q[$];
  logic [53:0] w, e;
  int errors = 0, checks = 0;

  projection_receiver #(.ADDR_BITS(AB), .FIFO_BITS(2)) dut (
    .clk(clk), .reset(reset), .en_proc(en_proc), .start(start),
    .projection(projection), .valid_proj(valid_proj),
    .valid_projPlus(valid_projPlus), .valid_projMinus(valid_projMinus),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_tc_index(rd_tc_index), .rd_index(rd_index), .rd_phi(rd_phi),
    .rd_z(rd_z), .rd_phider(rd_phider), .rd_zder(rd_zder),
    .nproj(nproj), .plus_data(plus_data), .plus_valid(plus_valid),
    .plus_ready(plus_ready), .minus_data(minus_data),
    .minus_valid(minus_valid), .minus_ready(minus_ready),
    .err_overflow(err_overflow), .err_multi(err_multi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [53:0] rnd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[53:0];
  endfunction

  task automatic wr_local(input logic [53:0] d, input bit keep);
    projection = d; valid_proj = 1; en_proc = 1;
    if (keep) loc_q.push_back(d);
    tick();
    valid_proj = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic rd_chk(input int a);
    rd_en = 1; rd_addr = AB'(a);
    tick();
    rd_en = 0;
    e = loc_q.pop_front();
    chk("rd_valid", 64'(rd_valid), 64'd1);
    chk("rd_word",
        64'({rd_tc_index, rd_index, rd_phi, rd_z, rd_phider, rd_zder}),
        64'({e[53:11], e[7:0]}));
  endtask

  task automatic do_reset();
    reset = 0;
    #2;
    reset = 1;
    tick();
  endtask

  initial begin
    #1 reset = 0;
    #1;
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_nproj", 64'(nproj), 64'd0);
    chk("rst_plus_valid", 64'(plus_valid), 64'd0);
    chk("rst_minus_data", 64'(minus_data), 64'd0);
    chk("rst_errs", 64'({err_overflow, err_multi}), 64'd0);
    #1 reset = 1;
    tick();

    // decode
    w = {4'h3, 6'd5, 14'h1ABC, 12'h801, 7'h40, 11'h07F};
    wr_local(w, 1);
    do_start();
    chk("dec_nproj", 64'(nproj), 64'd1);
    rd_en = 1; rd_addr = '0;
    tick();
    rd_en = 0;
    void'(loc_q.pop_front());
    chk("dec_valid", 64'(rd_valid), 64'd1);
    chk("dec_tc", 64'(rd_tc_index), 64'h3);
    chk("dec_index", 64'(rd_index), 64'd5);
    chk("dec_phi", 64'(rd_phi), 64'h1ABC);
    chk("dec_z", 64'($signed(rd_z)), 64'(-2047));
    chk("dec_phider", 64'($signed(rd_phider)), 64'(-64));
    chk("dec_zder", 64'($signed(rd_zder)), 64'd127);
    tick();
    chk("dec_rd_drop", 64'(rd_valid), 64'd0);
    chk("dec_hold", 64'(rd_phi), 64'h1ABC);

    // ping-pong
    for (int i = 0; i < 3; i++) wr_local(rnd(), 1);
    do_start();
    chk("pp_nproj1", 64'(nproj), 64'd3);
    for (int i = 0; i < 3; i++) rd_chk(i);
    for (int i = 0; i < 2; i++) wr_local(rnd(), 1);
    do_start();
    chk("pp_nproj2", 64'(nproj), 64'd2);
    for (int i = 0; i < 2; i++) rd_chk(i);

    // overflow and start-coincident write
    chk("ovf_clear", 64'(err_overflow), 64'd0);
    for (int i = 0; i < 65; i++) begin
      wr_local(rnd(), i < 64);
      if (i == 63) chk("ovf_at64", 64'(err_overflow), 64'd0);
    end
    chk("ovf_set", 64'(err_overflow), 64'd1);
    do_start();
    chk("ovf_nproj", 64'(nproj), 64'd64);
    for (int i = 0; i < 64; i++) rd_chk(i);
    wr_local(rnd(), 1);
    w = rnd();
    projection = w; valid_proj = 1; start = 1;
    loc_q.push_back(w);
    tick();
    valid_proj = 0; start = 0;
    chk("cstart_nproj", 64'(nproj), 64'd2);
    rd_chk(0);
    rd_chk(1);

    // plus FIFO: fill, overflow, drain
    do_reset();
    en_proc = 1;
    for (int i = 0; i < 5; i++) begin
      w = rnd();
      projection = w; valid_projPlus = 1;
      if (i < 4) pls_q.push_back(w);
      tick();
      if (i == 0) chk("fifo_valid1", 64'(plus_valid), 64'd1);
      if (i == 3) chk("fifo_noovf", 64'(err_overflow), 64'd0);
    end
    valid_projPlus = 0;
    chk("fifo_ovf", 64'(err_overflow), 64'd1);
    plus_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("fifo_dv", 64'(plus_valid), 64'd1);
      chk("fifo_data", 64'(plus_data), 64'(pls_q.pop_front()));
      tick();
    end
    chk("fifo_empty", 64'(plus_valid), 64'd0);
    plus_ready = 0;

    // push while full with simultaneous pop
    do_reset();
    en_proc = 1;
    for (int i = 0; i < 4; i++) begin
      w = rnd();
      projection = w; valid_projPlus = 1;
      pls_q.push_back(w);
      tick();
    end
    w = rnd();
    projection = w; plus_ready = 1;
    pls_q.push_back(w);
    chk("pp_head", 64'(plus_data), 64'(pls_q.pop_front()));
    tick();
    valid_projPlus = 0;
    for (int i = 0; i < 4; i++) begin
      chk("pp_dv", 64'(plus_valid), 64'd1);
      chk("pp_data", 64'(plus_data), 64'(pls_q.pop_front()));
      tick();
    end
    chk("pp_empty", 64'(plus_valid), 64'd0);
    chk("pp_noovf", 64'(err_overflow), 64'd0);
    plus_ready = 0;

    // priority and en_proc gating
    do_reset();
    w = rnd();
    projection = w; en_proc = 1;
    valid_proj = 1; valid_projMinus = 1;
    loc_q.push_back(w);
    tick();
    valid_projMinus = 0;
    chk("pri_multi", 64'(err_multi), 64'd1);
    chk("pri_minus", 64'(minus_valid), 64'd0);
    en_proc = 0; projection = rnd();
    tick();
    valid_proj = 0; en_proc = 1;
    chk("gate_multi", 64'(err_multi), 64'd1);
    do_start();
    chk("gate_nproj", 64'(nproj), 64'd1);
    rd_chk(0);

    // asynchronous reset mid-event
    wr_local(rnd(), 0);
    wr_local(rnd(), 0);
    do_start();
    chk("ar_pre_nproj", 64'(nproj), 64'd2);
    wr_local(rnd(), 0);
    w = rnd();
    projection = w; valid_projMinus = 1;
    mns_q.push_back(w);
    tick();
    valid_projMinus = 0;
    chk("ar_mvalid", 64'(minus_valid), 64'd1);
    chk("ar_mdata", 64'(minus_data), 64'(mns_q.pop_front()));
    rd_en = 1; rd_addr = '0;
    tick();
    rd_en = 0;
    chk("ar_pre_rdv", 64'(rd_valid), 64'd1);
    #2 reset = 0;
    #1;
    chk("ar_rd_valid", 64'(rd_valid), 64'd0);
    chk("ar_nproj", 64'(nproj), 64'd0);
    chk("ar_mvalid0", 64'(minus_valid), 64'd0);
    chk("ar_mdata0", 64'(minus_data), 64'd0);
    chk("ar_fields", 64'({rd_tc_index, rd_index, rd_phi, rd_z}), 64'd0);
    chk("ar_errs", 64'({err_overflow, err_multi}), 64'd0);
    reset = 1;
    tick();
    chk("ar_post_nproj", 64'(nproj), 64'd0);
    chk("ar_post_fifo", 64'({plus_valid, minus_valid}), 64'd0);
    do_start();
    chk("ar_post_start", 64'(nproj), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/projection_receiver.md
Name: projection_receiver

Overview:
- Receiving end of the tracklet projection interface.
- Accepts 54-bit projection words with local/plus/minus valid strobes from a tracklet projection calculator.
- Local projections go into a ping-pong per-event buffer. A downstream match engine reads that buffer with decoded fields.
- Plus- and minus-sector projections are queued in small FIFOs, each with a valid/ready handshake toward the neighbour-sector links.

Parameters:
- ADDR_BITS, 6, log2 of local buffer depth per bank (DEPTH = 2**ADDR_BITS = 64).
- FIFO_BITS, 2, log2 of plus/minus FIFO depth (4 entries each).

Ports:
- clk  in  1  processing clock.
- reset  in  1  asynchronous, active-low reset.
- en_proc  in  1  write enable; when low, all three valid strobes are ignored.
- start  in  1  event boundary pulse.
- projection  in  54  packed word; field layout in Behaviour.
- valid_proj  in  1  word belongs to the local sector.
- valid_projPlus  in  1  word belongs to the plus neighbour.
- valid_projMinus  in  1  word belongs to the minus neighbour.
- rd_en  in  1  read strobe, read bank.
- rd_addr  in  ADDR_BITS  read address.
- rd_valid  out  1  read data valid.
- rd_tc_index  out  4  decoded TC index.
- rd_index  out  6  decoded tracklet index.
- rd_phi  out  14  decoded phi projection, unsigned.
- rd_z  out  12  decoded z projection, signed.
- rd_phider  out  7  decoded phi derivative, signed.
- rd_zder  out  8  decoded z derivative, signed.
- nproj  out  ADDR_BITS+1  number of local entries in the read bank.
- plus_data  out  54  head of plus FIFO.
- plus_valid  out  1  plus FIFO non-empty.
- plus_ready  in  1  plus consumer accepts.
- minus_data  out  54  head of minus FIFO.
- minus_valid  out  1  minus FIFO non-empty.
- minus_ready  in  1  minus consumer accepts.
- err_overflow  out  1  sticky: a write was dropped (buffer or FIFO full).
- err_multi  out  1  sticky: more than one valid strobe asserted in the same cycle.

Behaviour:
- Field layout:
  - projection[53:50] TC index
  - [49:44] tracklet index
  - [43:30] phi
  - [29:18] z
  - [17:11] phi derivative
  - [10:0] spare/low bits; z derivative = [7:0]
  - Decoder maps these fields to rd_* outputs unchanged; signedness applies only to interpretation.
- Projection and its valid strobe arrive in the same cycle. A strobe counts only when en_proc=1.
- Strobe priority when several are high: local > minus > plus. Only the winner is written; err_multi is set.
- Local write:
  - Word stored in bank wr_bank at wr_cnt; wr_cnt then increments.
  - At wr_cnt = DEPTH the write is dropped, wr_cnt holds, and err_overflow is set.
- start:
  - nproj <= wr_cnt, including any local write in the same cycle.
  - wr_bank toggles; wr_cnt <= 0.
  - A local write in the start cycle lands in the old bank before the swap.
- Read bank is always ~wr_bank. Swap takes effect for reads issued the cycle after start.
- Read latency 1 cycle:
  - rd_valid = registered rd_en.
  - rd_* fields are registered and hold their value when rd_en=0.
  - rd_addr >= nproj returns stale memory contents with rd_valid=1; range-checking is the reader's responsibility.
- Plus/minus FIFOs:
  - First-word fall-through; *_valid rises the cycle after the first push.
  - Pop when *_valid & *_ready.
  - Push when full: accepted only if a pop happens in the same cycle; otherwise the word is dropped and err_overflow is set.
  - Push into empty with ready high: data appears next cycle; no bypass.
  - start does not flush the FIFOs.
- Reset (asynchronous, active-low) clears:
  - wr_bank=0, wr_cnt=0, nproj=0
  - rd_valid=0, all rd_* fields = 0
  - FIFO pointers; plus_valid=minus_valid=0, plus_data=minus_data=0
  - err_overflow=err_multi=0
  - Memory contents are not cleared.
- Reset asserted mid-event discards the partial event. Release is synchronised externally.

Test Plan:
- Decode: local write of {4'h3,6'd5,14'h1ABC,12'h801,7'h40,…,8'h7F}, then start, then rd_en at addr 0 -> next cycle rd_valid=1, tc=3, index=5, phi=0x1ABC, z=-2047, phider=-64, zder=127, nproj=1.
- Ping-pong: 3 local writes, start, 2 local writes, start -> after 1st start nproj=3; after 2nd start nproj=2 and reads return the second event's words.
- Overflow/boundary: 65 local writes in one event -> entries 0..63 stored, err_overflow=1, start gives nproj=64; write coincident with start is counted.
- FIFO handshake: 5 plus pushes with plus_ready=0 -> 4 held, err_overflow=1; raise ready -> 4 words drain in order, one per cycle, then plus_valid=0; push+pop while full -> no drop.
- Priority: valid_proj and valid_projMinus both high -> local written, minus FIFO stays empty, err_multi=1; en_proc=0 with valid_proj=1 -> no write.
- Async reset: assert reset low mid-event with no clock edge -> all outputs go to reset values immediately; after release nproj=0 and FIFOs are empty.
